// File: rtl/lgn_image_streamer.sv
// Byte-serial loader for the logic-gate-network classifier: shifts a binarized
// image in MSB-byte-first, waits for the network to settle, then returns its argmax.
module lgn_image_streamer #(
    parameter int INPUTS        = 256,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              img_valid,
    output logic              img_ready,
    input  logic [INPUTS-1:0] img_data,
    output logic [7:0]        dut_ui_in,
    output logic              dut_we_n,
    input  logic [3:0]        dut_index,
    input  logic [7:0]        dut_value,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [3:0]        res_index,
    output logic [7:0]        res_value,
    output logic              busy
);
    localparam int NBYTES = INPUTS / 8;
    localparam int CNT_W  = $clog2(NBYTES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND   = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(NBYTES - 1);
    localparam logic [7:0]       LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || (INPUTS % 8) != 0 || INPUTS < 8) begin : g_bad_params
        $error("lgn_image_streamer: illegal INPUTS/SETTLE_CYCLES");
    end

    logic [1:0]        state_q, state_d;
    logic [INPUTS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [7:0]        settle_q, settle_d;
    logic              res_valid_q, res_valid_d;
    logic [3:0]        res_index_q, res_index_d;
    logic [7:0]        res_value_q, res_value_d;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        settle_d    = settle_q;
        res_valid_d = res_valid_q;
        res_index_d = res_index_q;
        res_value_d = res_value_q;
        case (state_q)
            IDLE: begin
                if (img_valid) begin
                    shift_d    = img_data;
                    byte_cnt_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                shift_d    = shift_q << 8;
                byte_cnt_d = byte_cnt_q + 1'b1;
                // byte_cnt lands on NBYTES exactly as we leave, so it never wraps
                if (byte_cnt_q == LAST_BYTE) begin
                    settle_d = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == LAST_SETTLE) begin
                    res_index_d = dut_index;
                    res_value_d = dut_value;
                    res_valid_d = 1'b1;
                    state_d     = RESULT;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            byte_cnt_q  <= '0;
            settle_q    <= '0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_value_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            settle_q    <= settle_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_value_q <= res_value_d;
        end
    end

    // Pin outputs decode straight from registers so reset clears them without waiting for an edge
    assign img_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign dut_we_n  = (state_q != SEND);
    assign dut_ui_in = (state_q == SEND) ? shift_q[INPUTS-1 -: 8] : 8'h00;
    assign res_valid = res_valid_q;
    assign res_index = res_index_q;
    assign res_value = res_value_q;
endmodule

// File: tb/tb_lgn_image_streamer.sv
// Directed bench for lgn_image_streamer with a shift-register classifier model.
module tb_lgn_image_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, img_valid, res_ready;
    logic [255:0] img_data;
    logic         img_ready, dut_we_n, res_valid, busy;
    logic [7:0]   dut_ui_in, dut_value, res_value;
    logic [3:0]   dut_index, res_index;

    logic         img_valid_b, img_ready_b, we_n_b, res_valid_b, busy_b;
    logic [7:0]   ui_b, res_value_b;
    logic [3:0]   res_index_b;
    logic         img_valid_c, img_ready_c, we_n_c, res_valid_c, busy_c;
    logic [7:0]   ui_c, res_value_c;
    logic [3:0]   res_index_c;
    logic         rr_bc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    lgn_image_streamer #(.INPUTS(256), .SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .img_valid(img_valid), .img_ready(img_ready), .img_data(img_data),
        .dut_ui_in(dut_ui_in), .dut_we_n(dut_we_n), .dut_index(dut_index), .dut_value(dut_value),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index), .res_value(res_value),
        .busy(busy));

    lgn_image_streamer #(.INPUTS(256), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .img_valid(img_valid_b), .img_ready(img_ready_b), .img_data(img_data),
        .dut_ui_in(ui_b), .dut_we_n(we_n_b), .dut_index(4'd5), .dut_value(8'd77),
        .res_valid(res_valid_b), .res_ready(rr_bc), .res_index(res_index_b), .res_value(res_value_b),
        .busy(busy_b));

    lgn_image_streamer #(.INPUTS(256), .SETTLE_CYCLES(255)) dut_c (
        .clk(clk), .rst(rst), .img_valid(img_valid_c), .img_ready(img_ready_c), .img_data(img_data),
        .dut_ui_in(ui_c), .dut_we_n(we_n_c), .dut_index(4'd5), .dut_value(8'd77),
        .res_valid(res_valid_c), .res_ready(rr_bc), .res_index(res_index_c), .res_value(res_value_c),
        .busy(busy_c));

    // Classifier model: input register shifts left a byte per enabled cycle; argmax comes from its low bytes
    logic [255:0] cls_q;
    logic         ovr;
    logic [7:0]   ovr_val;
    always @(posedge clk) if (!dut_we_n) cls_q <= {cls_q[247:0], dut_ui_in};
    assign dut_index = cls_q[3:0];
    assign dut_value = ovr ? ovr_val : cls_q[15:8];

    always @(posedge clk) cyc <= cyc + 1;

    int          acc_q[$];
    logic [11:0] res_q[$];
    always @(posedge clk) begin
        if (!rst && img_valid && img_ready) acc_q.push_back(cyc);
        if (!rst && res_valid && res_ready) res_q.push_back({res_index, res_value});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [255:0] base, input logic [3:0] idx, input logic [7:0] val);
        logic [255:0] r;
        r = base;
        r[7:0]  = {4'h0, idx};
        r[15:8] = val;
        return r;
    endfunction

    initial begin
        logic [255:0] a, seq, frames[3];
        int n, bad, nb, nc;
        logic [11:0] rb, rc;

        rst = 1'b1; img_valid = 1'b0; res_ready = 1'b0; img_data = '0;
        ovr = 1'b0; ovr_val = 8'd0; img_valid_b = 1'b0; img_valid_c = 1'b0; rr_bc = 1'b1;
        repeat (3) tick();
        chk("reset_ready_we_busy", {img_ready, dut_we_n, busy}, {1'b1, 1'b1, 1'b0});
        chk("reset_ui", dut_ui_in, 8'h00);
        chk("reset_result", {res_valid, res_index, res_value}, 13'd0);
        rst = 1'b0;
        tick();

        // Reset in the middle of SEND
        a = {8{32'hDEAD_BEEF}} ^ {32{8'h5A}};
        img_data = a; img_valid = 1'b1;
        tick();
        img_valid = 1'b0;
        repeat (10) tick();
        chk("midsend_byte10", {dut_we_n, dut_ui_in}, {1'b0, a[255-80 -: 8]});
        rst = 1'b1;
        #1;
        chk("reset_async_outputs", {dut_we_n, dut_ui_in, img_ready, busy}, {1'b1, 8'h00, 1'b1, 1'b0});
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (res_valid !== 1'b0) bad++;
        end
        chk("no_partial_result", bad, 0);

        // Byte order 00..1F
        for (int i = 0; i < 32; i++) seq[255-8*i -: 8] = 8'(i);
        img_data = seq; img_valid = 1'b1; res_ready = 1'b1;
        tick();
        img_valid = 1'b0;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if ({dut_we_n, dut_ui_in} !== {1'b0, 8'(k)}) bad++;
            tick();
        end
        chk("byte_order_mismatches", bad, 0);
        chk("after_send", {dut_we_n, dut_ui_in}, {1'b1, 8'h00});
        chk("classifier_reg", cls_q, seq);
        repeat (10) tick();
        chk("byte_order_result_idle", {img_ready, busy}, {1'b1, 1'b0});

        // Result capture: index 7, score 143
        a = mk({8{32'h1234_5678}}, 4'd7, 8'd143);
        img_data = a; img_valid = 1'b1; res_ready = 1'b0;
        tick();
        img_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 400) begin tick(); n++; end
        chk("latency_settle4", n, 36);
        chk("capture", {res_index, res_value}, {4'd7, 8'd143});

        // Backpressure with a changing score and ignored image pulses
        ovr = 1'b1; ovr_val = 8'd99;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            img_valid = 1'(i % 2);
            img_data = ~a;
            tick();
            if (img_ready !== 1'b0 || res_valid !== 1'b1 || res_value !== 8'd143 || res_index !== 4'd7) bad++;
        end
        chk("backpressure_hold", bad, 0);
        img_valid = 1'b0; ovr = 1'b0; res_ready = 1'b1;
        tick();
        chk("release_to_idle", {res_valid, img_ready, busy}, {1'b0, 1'b1, 1'b0});
        chk("result_kept", {res_index, res_value}, {4'd7, 8'd143});

        // Three frames back to back
        frames[0] = mk({8{32'hCAFE_F00D}}, 4'd3, 8'h40);
        frames[1] = mk({8{32'h0F1E_2D3C}}, 4'd0, 8'h41);
        frames[2] = mk({8{32'h8899_AABB}}, 4'd9, 8'h42);
        acc_q.delete(); res_q.delete();
        img_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            img_data = frames[f];
            n = 0;
            while (acc_q.size() < f + 1 && n < 100) begin tick(); n++; end
        end
        img_valid = 1'b0;
        n = 0;
        while (res_q.size() < 3 && n < 200) begin tick(); n++; end
        chk("b2b_accepts", acc_q.size(), 3);
        chk("b2b_results", res_q.size(), 3);
        if (acc_q.size() == 3 && res_q.size() == 3) begin
            chk("b2b_gap01", acc_q[1] - acc_q[0], 38);
            chk("b2b_gap12", acc_q[2] - acc_q[1], 38);
            chk("b2b_res0", res_q[0], {4'd3, 8'h40});
            chk("b2b_res1", res_q[1], {4'd0, 8'h41});
            chk("b2b_res2", res_q[2], {4'd9, 8'h42});
        end

        // Settle parameter extremes
        img_valid_b = 1'b1; img_valid_c = 1'b1;
        tick();
        img_valid_b = 1'b0; img_valid_c = 1'b0;
        n = 0; nb = 0; nc = 0; rb = '0; rc = '0;
        while ((nb == 0 || nc == 0) && n < 400) begin
            tick(); n++;
            if (res_valid_b && nb == 0) begin nb = n; rb = {res_index_b, res_value_b}; end
            if (res_valid_c && nc == 0) begin nc = n; rc = {res_index_c, res_value_c}; end
        end
        chk("latency_settle1", nb, 33);
        chk("latency_settle255", nc, 287);
        chk("settle1_result", rb, {4'd5, 8'd77});
        chk("settle255_result", rc, {4'd5, 8'd77});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
